// File: rtl/com_loader_pkg.sv
// com_loader_pkg: state encoding, protocol byte codes and small helpers
// shared by the host-link program loader.
// Optional feature macro: COM_LOADER_CHECKSUM_EN (adds the CSUM state).
package com_loader_pkg;

    // Loader FSM states; CSUM exists only when the checksum byte is enabled.
    typedef enum logic [2:0] {
        IDLE,
        ADDR_H,
        ADDR_L,
        DATA_H,
        DATA_L,
`ifdef COM_LOADER_CHECKSUM_EN
        CSUM,
`endif
        WRITE,
        RESP
    } state_t;

    // Command bytes received from the host.
    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_HALT  = 8'h48;
    localparam logic [7:0] CMD_GO    = 8'h47;

    // Response bytes sent to the host.
    localparam logic [7:0] RSP_ACK  = 8'h06;
    localparam logic [7:0] RSP_NAK  = 8'h15;
    localparam logic [7:0] RSP_DONE = 8'h44;

    // True for states that wait on further bytes of a 'W' packet and are
    // therefore subject to the inter-byte timeout.
    function automatic logic is_collect_state(input state_t s);
        logic r;
        r = (s == ADDR_H) || (s == ADDR_L) || (s == DATA_H) || (s == DATA_L);
`ifdef COM_LOADER_CHECKSUM_EN
        r = r || (s == CSUM);
`endif
        return r;
    endfunction

endpackage

// File: rtl/com_loader_timer.sv
// com_loader_timer: inter-byte idle timer. Counts consecutive idle cycles
// while armed, restarts on every received byte, and flags the cycle that
// completes TIMEOUT_CYCLES idle cycles.
module com_loader_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic clk1,
    input  logic rst,
    input  logic load,
    input  logic count_en,
    output logic expired
);

    localparam int unsigned LIMIT = (TIMEOUT_CYCLES < 1) ? 1 : TIMEOUT_CYCLES;
    localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: restart on a byte or when disarmed, otherwise count up to LAST.
    always_comb begin
        count_d = count_q;
        if (load || !count_en) begin
            count_d = '0;
        end else if (count_q != LAST) begin
            count_d = count_q + CW'(1);
        end
    end

    // Idle-cycle counter register.
    always_ff @(posedge clk1) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = count_en && !load && (count_q == LAST);

endmodule

// File: rtl/com_loader.sv
// com_loader: host-link program loader. Receives 'W' (write word), 'G' (run
// processor) and 'H' (halt processor) packets, drives the memory write port
// while the processor is halted, and reports processor completion with 'D'.
// Optional feature macro: COM_LOADER_CHECKSUM_EN adds a sixth checksum byte
// to 'W' packets.
module com_loader
    import com_loader_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic        clk1,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic        ENDda,
    output logic        ComENNot,
    output logic [15:0] AddFromCom,
    output logic [15:0] DatFromCom,
    output logic        WriteFromCom,
    output logic        busy
);

    state_t      state_q, state_d;
    logic [15:0] addr_buf_q, addr_buf_d;
    logic [7:0]  data_hi_q, data_hi_d;
    logic [15:0] add_q, add_d;
    logic [15:0] dat_q, dat_d;
    logic        write_q, write_d;
    logic        tx_valid_q, tx_valid_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        com_en_q, com_en_d;
    logic        d_pending_q, d_pending_d;
    logic        endda_q;
    logic        end_rise;
    logic        send_done;
    logic        timer_expired;
`ifdef COM_LOADER_CHECKSUM_EN
    logic [7:0]  data_lo_q, data_lo_d;
    logic [7:0]  csum_q, csum_d;
`endif

    com_loader_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk1     (clk1),
        .rst      (rst),
        .load     (rx_valid),
        .count_en (is_collect_state(state_q)),
        .expired  (timer_expired)
    );

    // Processor end flag only matters while the processor is running.
    assign end_rise = ENDda && !endda_q && com_en_q;

    // A single 'D' slot: set on a qualifying end edge, freed when sent.
    assign d_pending_d = end_rise || (d_pending_q && !send_done);

    // State register.
    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: one state per received byte, rejects go straight to RESP.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    if ((rx_data == CMD_WRITE) && !com_en_q) begin
                        state_d = ADDR_H;
                    end else begin
                        state_d = RESP;
                    end
                end else if (d_pending_q) begin
                    state_d = RESP;
                end
            end
            ADDR_H: begin
                if (rx_valid) begin
                    state_d = ADDR_L;
                end else if (timer_expired) begin
                    state_d = IDLE;
                end
            end
            ADDR_L: begin
                if (rx_valid) begin
                    state_d = DATA_H;
                end else if (timer_expired) begin
                    state_d = IDLE;
                end
            end
            DATA_H: begin
                if (rx_valid) begin
                    state_d = DATA_L;
                end else if (timer_expired) begin
                    state_d = IDLE;
                end
            end
            DATA_L: begin
                if (rx_valid) begin
`ifdef COM_LOADER_CHECKSUM_EN
                    state_d = CSUM;
`else
                    state_d = WRITE;
`endif
                end else if (timer_expired) begin
                    state_d = IDLE;
                end
            end
`ifdef COM_LOADER_CHECKSUM_EN
            CSUM: begin
                if (rx_valid) begin
                    state_d = (rx_data == csum_q) ? WRITE : RESP;
                end else if (timer_expired) begin
                    state_d = IDLE;
                end
            end
`endif
            WRITE: begin
                state_d = RESP;
            end
            RESP: begin
                if (tx_valid_q && tx_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output and datapath logic: byte capture, write strobe, responses, run flag.
    always_comb begin
        addr_buf_d = addr_buf_q;
        data_hi_d  = data_hi_q;
        add_d      = add_q;
        dat_d      = dat_q;
        write_d    = 1'b0;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        com_en_d   = com_en_q;
        send_done  = 1'b0;
`ifdef COM_LOADER_CHECKSUM_EN
        data_lo_d  = data_lo_q;
        csum_d     = csum_q;
        if (rx_valid && is_collect_state(state_q)) begin
            csum_d = csum_q + rx_data;
        end
`endif
        case (state_q)
            IDLE: begin
                if (rx_valid) begin
`ifdef COM_LOADER_CHECKSUM_EN
                    csum_d = rx_data;
`endif
                    case (rx_data)
                        CMD_WRITE: begin
                            if (com_en_q) begin
                                tx_valid_d = 1'b1;
                                tx_data_d  = RSP_NAK;
                            end
                        end
                        CMD_GO: begin
                            com_en_d   = 1'b1;
                            tx_valid_d = 1'b1;
                            tx_data_d  = RSP_ACK;
                        end
                        CMD_HALT: begin
                            com_en_d   = 1'b0;
                            tx_valid_d = 1'b1;
                            tx_data_d  = RSP_ACK;
                        end
                        default: begin
                            tx_valid_d = 1'b1;
                            tx_data_d  = RSP_NAK;
                        end
                    endcase
                end else if (d_pending_q) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = RSP_DONE;
                    send_done  = 1'b1;
                end
            end
            ADDR_H: begin
                if (rx_valid) begin
                    addr_buf_d[15:8] = rx_data;
                end
            end
            ADDR_L: begin
                if (rx_valid) begin
                    addr_buf_d[7:0] = rx_data;
                end
            end
            DATA_H: begin
                if (rx_valid) begin
                    data_hi_d = rx_data;
                end
            end
            DATA_L: begin
                if (rx_valid) begin
`ifdef COM_LOADER_CHECKSUM_EN
                    data_lo_d = rx_data;
`else
                    add_d   = addr_buf_q;
                    dat_d   = {data_hi_q, rx_data};
                    write_d = 1'b1;
`endif
                end
            end
`ifdef COM_LOADER_CHECKSUM_EN
            CSUM: begin
                if (rx_valid) begin
                    if (rx_data == csum_q) begin
                        add_d   = addr_buf_q;
                        dat_d   = {data_hi_q, data_lo_q};
                        write_d = 1'b1;
                    end else begin
                        tx_valid_d = 1'b1;
                        tx_data_d  = RSP_NAK;
                    end
                end
            end
`endif
            WRITE: begin
                tx_valid_d = 1'b1;
                tx_data_d  = RSP_ACK;
            end
            RESP: begin
                if (tx_valid_q && tx_ready) begin
                    tx_valid_d = 1'b0;
                end
            end
            default: begin
                tx_valid_d = 1'b0;
            end
        endcase
        if (end_rise) begin
            com_en_d = 1'b0;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk1) begin
        if (rst) begin
            addr_buf_q  <= '0;
            data_hi_q   <= '0;
            add_q       <= '0;
            dat_q       <= '0;
            write_q     <= 1'b0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= '0;
            com_en_q    <= 1'b0;
            d_pending_q <= 1'b0;
            endda_q     <= 1'b0;
`ifdef COM_LOADER_CHECKSUM_EN
            data_lo_q   <= '0;
            csum_q      <= '0;
`endif
        end else begin
            addr_buf_q  <= addr_buf_d;
            data_hi_q   <= data_hi_d;
            add_q       <= add_d;
            dat_q       <= dat_d;
            write_q     <= write_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
            com_en_q    <= com_en_d;
            d_pending_q <= d_pending_d;
            endda_q     <= ENDda;
`ifdef COM_LOADER_CHECKSUM_EN
            data_lo_q   <= data_lo_d;
            csum_q      <= csum_d;
`endif
        end
    end

    assign tx_data      = tx_data_q;
    assign tx_valid     = tx_valid_q;
    assign ComENNot     = com_en_q;
    assign AddFromCom   = add_q;
    assign DatFromCom   = dat_q;
    assign WriteFromCom = write_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_com_loader.sv
// tb_com_loader: scoreboard bench for com_loader. Expected response bytes
// and memory writes are queued as packets are sent and consumed when the
// DUT completes a tx handshake or pulses WriteFromCom.
// Honours COM_LOADER_CHECKSUM_EN to append the checksum byte.
module tb_com_loader;
    import com_loader_pkg::*;

    localparam int unsigned TO = 20;

    logic        clk1;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        ENDda;
    logic        ComENNot;
    logic [15:0] AddFromCom;
    logic [15:0] DatFromCom;
    logic        WriteFromCom;
    logic        busy;

    int compare_count  = 0;
    int mismatch_count = 0;
    int tx_seen        = 0;
    int tx_expect      = 0;

    logic [7:0]  tx_q[$];
    logic [31:0] wr_q[$];

    com_loader #(
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk1         (clk1),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .ENDda        (ENDda),
        .ComENNot     (ComENNot),
        .AddFromCom   (AddFromCom),
        .DatFromCom   (DatFromCom),
        .WriteFromCom (WriteFromCom),
        .busy         (busy)
    );

    // Free-running clock.
    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    // Counts one comparison and reports it when the observed value differs.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compare_count++;
        if (actual !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drives one byte for exactly one cycle; called just after a rising edge.
    task automatic applyStimulus(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk1);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic stepCycle();
        @(posedge clk1);
        #1;
    endtask

    task automatic expectTx(input logic [7:0] b);
        tx_q.push_back(b);
        tx_expect++;
    endtask

    // Waits, bounded, until every queued response byte has been handed over.
    task automatic waitTx();
        for (int i = 0; i < 200 && tx_seen < tx_expect; i++) begin
            stepCycle();
        end
        checkOutput("txCount", 32'(tx_seen), 32'(tx_expect));
    endtask

    // Sends a full 'W' packet and checks the strobe cycle directly.
    task automatic sendWrite(input logic [15:0] a, input logic [15:0] d, input bit good);
`ifdef COM_LOADER_CHECKSUM_EN
        logic [7:0] sum;
        sum = 8'h57 + a[15:8] + a[7:0] + d[15:8] + d[7:0];
`endif
        if (good) begin
            wr_q.push_back({a, d});
            expectTx(8'h06);
        end else begin
            expectTx(8'h15);
        end
        applyStimulus(8'h57);
        applyStimulus(a[15:8]);
        applyStimulus(a[7:0]);
        applyStimulus(d[15:8]);
        applyStimulus(d[7:0]);
`ifdef COM_LOADER_CHECKSUM_EN
        applyStimulus(good ? sum : 8'h00);
`endif
        checkOutput("writeStrobe", 32'(WriteFromCom), 32'(good));
        if (good) begin
            checkOutput("writeAddr", 32'(AddFromCom), 32'(a));
            checkOutput("writeData", 32'(DatFromCom), 32'(d));
        end
        waitTx();
    endtask

    // Scoreboard monitor: consumes expectations on handshakes and strobes.
    always @(negedge clk1) begin
        logic [7:0]  exp_b;
        logic [31:0] exp_w;
        if (!rst) begin
            if (tx_valid && tx_ready) begin
                if (tx_q.size() == 0) begin
                    checkOutput("unexpectedTx", 32'(tx_data), 32'hFFFF_FFFF);
                end else begin
                    exp_b = tx_q.pop_front();
                    checkOutput("txByte", 32'(tx_data), 32'(exp_b));
                end
                tx_seen++;
            end
            if (WriteFromCom) begin
                if (wr_q.size() == 0) begin
                    checkOutput("unexpectedWrite", {AddFromCom, DatFromCom}, 32'hFFFF_FFFF);
                end else begin
                    exp_w = wr_q.pop_front();
                    checkOutput("writeWord", {AddFromCom, DatFromCom}, exp_w);
                end
            end
        end
    end

    // Safety net against a hung run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main stimulus sequence.
    initial begin
        rst      = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        ENDda    = 1'b0;
        repeat (3) stepCycle();
        rst = 1'b0;

        $display("[TB] reset values");
        checkOutput("rstTxValid", 32'(tx_valid), 32'd0);
        checkOutput("rstTxData", 32'(tx_data), 32'd0);
        checkOutput("rstComEn", 32'(ComENNot), 32'd0);
        checkOutput("rstWrite", 32'(WriteFromCom), 32'd0);
        checkOutput("rstAddr", 32'(AddFromCom), 32'd0);
        checkOutput("rstData", 32'(DatFromCom), 32'd0);
        checkOutput("rstBusy", 32'(busy), 32'd0);

        $display("[TB] write packets");
        sendWrite(16'h0010, 16'hABCD, 1'b1);
        repeat (3) stepCycle();
        checkOutput("addrHeld", 32'(AddFromCom), 32'h0010);
        checkOutput("dataHeld", 32'(DatFromCom), 32'hABCD);
        checkOutput("strobeLow", 32'(WriteFromCom), 32'd0);
        sendWrite(16'hFFFF, 16'h1234, 1'b1);

        $display("[TB] unknown command and halt");
        expectTx(8'h15);
        applyStimulus(8'h33);
        waitTx();
        expectTx(8'h06);
        applyStimulus(8'h48);
        waitTx();
        checkOutput("haltComEn", 32'(ComENNot), 32'd0);

        $display("[TB] go, rejected write, repeated go");
        expectTx(8'h06);
        applyStimulus(8'h47);
        checkOutput("goComEn", 32'(ComENNot), 32'd1);
        waitTx();
        expectTx(8'h15);
        applyStimulus(8'h57);
        checkOutput("rejectNoStrobe", 32'(WriteFromCom), 32'd0);
        waitTx();
        expectTx(8'h06);
        applyStimulus(8'h47);
        waitTx();
        checkOutput("goAgainComEn", 32'(ComENNot), 32'd1);

        $display("[TB] end flag while idle");
        expectTx(8'h44);
        ENDda = 1'b1;
        checkOutput("endBeforeEdge", 32'(ComENNot), 32'd1);
        stepCycle();
        checkOutput("endClearsComEn", 32'(ComENNot), 32'd0);
        waitTx();
        ENDda = 1'b0;
        stepCycle();

        $display("[TB] end flag during stalled response");
        tx_ready = 1'b0;
        expectTx(8'h06);
        expectTx(8'h44);
        applyStimulus(8'h47);
        checkOutput("stallTxValid", 32'(tx_valid), 32'd1);
        ENDda = 1'b1;
        repeat (10) stepCycle();
        checkOutput("stallHeldValid", 32'(tx_valid), 32'd1);
        checkOutput("stallHeldData", 32'(tx_data), 32'h06);
        checkOutput("stallComEn", 32'(ComENNot), 32'd0);
        tx_ready = 1'b1;
        waitTx();
        ENDda = 1'b0;
        stepCycle();

        $display("[TB] inter-byte timeout");
        applyStimulus(8'h57);
        applyStimulus(8'h12);
        repeat (TO - 1) stepCycle();
        checkOutput("busyBeforeTimeout", 32'(busy), 32'd1);
        stepCycle();
        checkOutput("busyAfterTimeout", 32'(busy), 32'd0);
        expectTx(8'h06);
        applyStimulus(8'h48);
        waitTx();

`ifdef COM_LOADER_CHECKSUM_EN
        $display("[TB] checksum packets");
        sendWrite(16'h0001, 16'h0002, 1'b1);
        sendWrite(16'h0001, 16'h0002, 1'b0);
`endif

        $display("[TB] reset mid-packet");
        applyStimulus(8'h57);
        applyStimulus(8'h00);
        applyStimulus(8'h01);
        rst = 1'b1;
        repeat (2) stepCycle();
        checkOutput("midRstBusy", 32'(busy), 32'd0);
        checkOutput("midRstWrite", 32'(WriteFromCom), 32'd0);
        checkOutput("midRstAddr", 32'(AddFromCom), 32'd0);
        checkOutput("midRstData", 32'(DatFromCom), 32'd0);
        checkOutput("midRstTxValid", 32'(tx_valid), 32'd0);
        checkOutput("midRstComEn", 32'(ComENNot), 32'd0);
        rst = 1'b0;
        stepCycle();
        expectTx(8'h06);
        applyStimulus(8'h48);
        waitTx();

        repeat (5) stepCycle();
        checkOutput("txQueueLeft", 32'(tx_q.size()), 32'd0);
        checkOutput("writeQueueLeft", 32'(wr_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule

// File: doc/com_loader.md
COM_LOADER -- requirements
Module: com_loader

Interface
- REQ-001 Parameter TIMEOUT_CYCLES, default 65535: idle cycles allowed between bytes of one packet before the packet is abandoned.
- REQ-002 clk1  input  1  system clock; all logic on rising edge.
- REQ-003 rst  input  1  synchronous, active-high reset.
- REQ-004 rx_data  input  8  received byte from host link.
- REQ-005 rx_valid  input  1  one-cycle strobe: rx_data valid this cycle.
- REQ-006 tx_data  output  8  response byte to host.
- REQ-007 tx_valid  output  1  response byte offered; held until tx_ready.
- REQ-008 tx_ready  input  1  host link accepts tx_data when tx_valid&&tx_ready.
- REQ-009 ENDda  input  1  processor end flag; rising edge means program finished.
- REQ-010 ComENNot  output  1  0 = loader owns memory, processor clock stopped; 1 = processor runs.
- REQ-011 AddFromCom  output  16  memory write address.
- REQ-012 DatFromCom  output  16  memory write data.
- REQ-013 WriteFromCom  output  1  one-cycle memory write strobe.
- REQ-014 busy  output  1  high whenever state is not IDLE.

Function
- REQ-015 Packet format SHALL be: command byte, then for 'W' (0x57) addr_hi, addr_lo, data_hi, data_lo; 'H' (0x48) and 'G' (0x47) are single-byte.
- REQ-016 States SHALL be IDLE, ADDR_H, ADDR_L, DATA_H, DATA_L, [CSUM], WRITE, RESP; rx_valid advances one state per byte.
- REQ-017 WriteFromCom SHALL pulse exactly one cycle, the cycle after data_lo is accepted; AddFromCom/DatFromCom valid that cycle and held until the next write.
- REQ-018 RESP SHALL present tx_valid the cycle after WRITE (or after a single-byte command) and return to IDLE on tx_valid&&tx_ready.
- REQ-019 Response bytes: ACK 0x06 on success; NAK 0x15 on unknown command, on 'W' while ComENNot=1, or on checksum mismatch; NAK'd 'W' SHALL skip WRITE (no strobe); unknown/rejected command byte SHALL NOT consume following bytes.
- REQ-020 'G' SHALL set ComENNot=1 and ACK; 'H' SHALL set ComENNot=0 and ACK; repeats are idempotent and still ACK.
- REQ-021 ENDda rising edge while ComENNot=1 SHALL clear ComENNot the next cycle and queue byte 'D' (0x44); queue depth one, duplicate edges while pending are merged.
- REQ-022 A queued 'D' SHALL be sent from IDLE only; if ENDda rises during RESP, the ACK/NAK goes first, 'D' after its handshake.
- REQ-023 rx_valid in WRITE or RESP SHALL be dropped; host waits for a response before sending.
- REQ-024 In ADDR_H..DATA_L/CSUM, TIMEOUT_CYCLES consecutive cycles without rx_valid SHALL return to IDLE silently with no write.
- REQ-025 Byte assembly: addr = {addr_hi,addr_lo}, data = {data_hi,data_lo}; no wrap or range check on address.

Reset
- REQ-026 rst SHALL force: state IDLE, ComENNot=0, WriteFromCom=0, tx_valid=0, tx_data=0x00, AddFromCom=0, DatFromCom=0, busy=0, pending 'D' cleared, timer cleared.
- REQ-027 rst mid-packet SHALL abandon the packet with no strobe; rst overrides all simultaneous events.

Configuration
- REQ-028 Macro COM_LOADER_CHECKSUM_EN defined: 'W' SHALL carry a sixth byte (CSUM state) equal to 8-bit sum of the five preceding bytes; mismatch -> NAK, no write.
- REQ-029 Macro undefined: CSUM state absent, 'W' is five bytes, no checksum logic.

Structure
- REQ-030 Package com_loader_pkg SHALL hold the state enum, command codes (0x57/0x48/0x47), response codes (0x06/0x15/0x44).
- REQ-031 Inter-byte timer SHALL be sub-module com_loader_timer (load on byte, count, expire flag).

Verification
- REQ-032 Reset, then 'W',0x00,0x10,0xAB,0xCD -> one-cycle WriteFromCom, AddFromCom=0x0010, DatFromCom=0xABCD, tx 0x06.
- REQ-033 'G' -> ComENNot=1, ACK; then 'W',... -> NAK 0x15, no WriteFromCom.
- REQ-034 ComENNot=1, ENDda 0->1 -> ComENNot=0 next cycle, tx 0x44; ENDda rising during RESP with tx_ready low 10 cycles -> 0x06 then 0x44.
- REQ-035 'W',0x12 then silence TIMEOUT_CYCLES -> busy=0, no strobe; next 'H' ACKed.
- REQ-036 With COM_LOADER_CHECKSUM_EN: 'W',0,1,0,2,0x5A -> ACK, write; checksum 0x00 -> NAK, no write; rst asserted after addr_lo -> no strobe, all outputs at reset values.
